// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM encoding for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply, restoring divide when MULDIV_DIV_EN is defined.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] upper,
  output logic [WIDTH-1:0] lower,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] next_upper;
  logic [WIDTH-1:0] next_lower;
  logic [WIDTH:0]   sum;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shifted;
  logic             fits;
`endif

  assign last = (count == CW'(WIDTH - 1));

  // NOTE: always_comb assigns every output first so no path leaves a value held, which would infer a latch.
  always_comb begin
    sum        = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
    next_upper = sum[WIDTH:1];
    next_lower = {sum[0], lower[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted    = {upper, lower[WIDTH-1]};
    fits       = (shifted >= {1'b0, operand});
    if (div_mode) begin
      // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
      next_upper = fits ? (shifted[WIDTH-1:0] - operand) : shifted[WIDTH-1:0];
      next_lower = {lower[WIDTH-2:0], fits};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upper   <= '0;
      lower   <= '0;
      operand <= '0;
      count   <= '0;
    end else if (start) begin
      upper   <= '0;
      lower   <= div_mode ? op_a : op_b;
      operand <= div_mode ? op_b : op_a;
      count   <= '0;
    end else if (step) begin
      upper   <= next_upper;
      lower   <= next_lower;
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage HI/LO owner: funct decode, IDLE/RUN/FIX sequencing, stall and sign fix-up.
// Define MULDIV_DIV_EN to build the divide hardware; otherwise DIV/DIVU are accepted as no-ops.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state_q, state_d;

  logic [5:0] opcode, funct;
  logic       is_mfhi, is_mthi, is_mflo, is_mtlo, is_mul, is_div, is_class;
  logic       accept, start_op, step, last;
  logic       a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, upper, lower, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic       neg_q;
  logic       unused_instr_bits;

`ifdef MULDIV_DIV_EN
  logic             op_div_q, neg_r_q, div_zero_q;
  logic [WIDTH-1:0] dividend_q;
`endif

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    is_mfhi = 1'b0;
    is_mthi = 1'b0;
    is_mflo = 1'b0;
    is_mtlo = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FUNCT_MFHI:              is_mfhi = 1'b1;
        FUNCT_MTHI:              is_mthi = 1'b1;
        FUNCT_MFLO:              is_mflo = 1'b1;
        FUNCT_MTLO:              is_mtlo = 1'b1;
        FUNCT_MULT, FUNCT_MULTU: is_mul  = 1'b1;
        FUNCT_DIV, FUNCT_DIVU:   is_div  = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_class    = is_mfhi | is_mthi | is_mflo | is_mtlo | is_mul | is_div;
  assign busy        = (state_q != IDLE);
  assign stall       = instr_valid & is_class & busy;
  assign accept      = instr_valid & is_class & ~busy;
  assign rdata_valid = accept & (is_mfhi | is_mflo);
  assign rdata       = (accept & is_mfhi) ? hi : (accept & is_mflo) ? lo : '0;

`ifdef MULDIV_DIV_EN
  assign start_op = accept & (is_mul | is_div);
`else
  assign start_op = accept & is_mul;
`endif

  // Signed ops run on magnitudes; the sign is restored in FIX.
  assign a_neg = ((funct == FUNCT_MULT) || (funct == FUNCT_DIV)) && rs_val[WIDTH-1];
  assign b_neg = ((funct == FUNCT_MULT) || (funct == FUNCT_DIV)) && rt_val[WIDTH-1];
  assign mag_a = a_neg ? -rs_val : rs_val;
  assign mag_b = b_neg ? -rt_val : rt_val;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_op),
    .step     (step),
    .div_mode (is_div),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .upper    (upper),
    .lower    (lower),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    case (state_q)
      IDLE: if (start_op) state_d = RUN;
      RUN: begin
        step = 1'b1;
        if (last) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prod   = neg_q ? -{upper, lower} : {upper, lower};
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (op_div_q) begin
      if (div_zero_q) begin
        fix_hi = dividend_q;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r_q ? -upper : upper;
        fix_lo = neg_q   ? -lower : lower;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      neg_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_q   <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start_op) begin
        neg_q      <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
        op_div_q   <= is_div;
        neg_r_q    <= a_neg;
        div_zero_q <= (rt_val == '0);
        dividend_q <= rs_val;
`endif
      end
    end
  end

  // FIX and MTHI/MTLO can never coincide: moves are only accepted while not busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else begin
      if (accept & is_mthi) hi <= rs_val;
      if (accept & is_mtlo) lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: MFHI/MFLO reads push expectations, a monitor pops on rdata_valid.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr, rs_val, rt_val;
  logic        stall, busy, rdata_valid;
  logic [31:0] rdata, hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .stall       (stall),
    .busy        (busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdata_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected: got %h expected no read", rdata);
      end else begin
        check("rdata", rdata, sb.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    instr_valid = v;
    instr       = {op, 20'd0, f};
    rs_val      = a;
    rt_val      = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents MFHI/MFLO until it is no longer stalled; reports how many cycles it stalled.
  task automatic mf_read(input logic [5:0] f, input logic [31:0] exp, output int stalls);
    sb.push_back(exp);
    drive(1'b1, OP_RTYPE, f, 32'h0, 32'h0);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
      tick();
    end
    tick();
    drive(1'b0, OP_RTYPE, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo);
    logic skip;
    int   n;
    int   s;
    skip = ((f == FUNCT_DIV) || (f == FUNCT_DIVU)) && !DIV_EN;
    if (!skip) begin
      m_hi = e_hi;
      m_lo = e_lo;
    end
    drive(1'b1, OP_RTYPE, f, a, b);
    @(negedge clk);
    check({name, "_issue_stall"}, {31'd0, stall}, 32'd0);
    tick();
    drive(1'b0, OP_RTYPE, 6'h00, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      tick();
    end
    tick();
    check({name, "_busy_cycles"}, 32'(n), skip ? 32'd0 : 32'd33);
    check({name, "_hi"}, hi, m_hi);
    check({name, "_lo"}, lo, m_lo);
    mf_read(FUNCT_MFHI, m_hi, s);
    check({name, "_mfhi_stall"}, 32'(s), 32'd0);
    mf_read(FUNCT_MFLO, m_lo, s);
  endtask

  initial begin
    int s;
    logic [5:0] long_op;
    rst_n = 1'b0;
    drive(1'b0, OP_RTYPE, 6'h00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_neg",   FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negd",  FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_zero", FUNCT_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op("div_ovf",   FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    run_op("divu_7",    FUNCT_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142);

    // Back-to-back MFLO behind a MULT stalls for the whole operation.
    drive(1'b1, OP_RTYPE, FUNCT_MULT, 32'd6, 32'd7);
    tick();
    m_hi = 32'h0;
    m_lo = 32'd42;
    mf_read(FUNCT_MFLO, m_lo, s);
    check("b2b_mflo_stall", 32'(s), 32'd33);
    mf_read(FUNCT_MFHI, m_hi, s);

    // Non-class instructions pass through while busy.
    drive(1'b1, OP_RTYPE, FUNCT_MULTU, 32'd1, 32'd1);
    tick();
    drive(1'b1, OP_RTYPE, 6'h20, 32'd5, 32'd9);
    @(negedge clk);
    check("add_busy", {31'd0, busy}, 32'd1);
    check("add_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, 6'h23, FUNCT_MFHI, 32'd5, 32'd9);
    @(negedge clk);
    check("lw_stall", {31'd0, stall}, 32'd0);
    check("lw_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    tick();
    m_hi = 32'h0;
    m_lo = 32'd1;
    mf_read(FUNCT_MFLO, m_lo, s);
    check("multu1_mflo_stall_bounded", 32'(s < 40), 32'd1);

    // MTHI then MFHI back to back.
    drive(1'b1, OP_RTYPE, FUNCT_MTHI, 32'h1234, 32'h0);
    @(negedge clk);
    check("mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    m_hi = 32'h1234;
    mf_read(FUNCT_MFHI, m_hi, s);
    check("mfhi_after_mthi_stall", 32'(s), 32'd0);
    drive(1'b1, OP_RTYPE, FUNCT_MTLO, 32'h00AA, 32'h0);
    tick();
    m_lo = 32'h00AA;

    // Reset in the middle of a long operation discards it.
    long_op = DIV_EN ? FUNCT_DIVU : FUNCT_MULTU;
    drive(1'b1, OP_RTYPE, long_op, 32'd1000, 32'd7);
    tick();
    drive(1'b0, OP_RTYPE, 6'h00, 32'h0, 32'h0);
    repeat (9) tick();
    @(negedge clk);
    check("midop_busy", {31'd0, busy}, 32'd1);
    check("midop_hi", hi, 32'h1234);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    tick();
    rst_n = 1'b1;
    tick();
    run_op("multu_2x3", FUNCT_MULTU, 32'd2, 32'd3, 32'h0, 32'd6);

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
